instruction_decode: RTL

INSTRUCTION_DECODE -- requirements
Module: instruction_decode

---
 rtl/instruction_decode_pkg.sv | 121 ++++++++++++
 rtl/instruction_decode_register_file.sv | 47 ++++
 rtl/instruction_decode.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/instruction_decode_pkg.sv
// Shared decode definitions for the ID stage.
// Holds the opcode and funct constants, the control-word layout, the ALU
// operation codes, and helpers that map an opcode/funct pair to a control word.
package instruction_decode_pkg;

  localparam int NB_RADDR = 5;

  // Control word layout, MSB first:
  // {regwrite, memtoreg, memread, memwrite, alusrc, regdst, link, aluop[3:0]}
  localparam int CTRL_W        = 11;
  localparam int CTRL_REGWRITE = 10;
  localparam int CTRL_MEMTOREG = 9;
  localparam int CTRL_MEMREAD  = 8;
  localparam int CTRL_MEMWRITE = 7;
  localparam int CTRL_ALUSRC   = 6;
  localparam int CTRL_REGDST   = 5;
  localparam int CTRL_LINK     = 4;
  localparam int CTRL_ALUOP_W  = 4;

  // ALU operation codes carried in aluop
  localparam logic [3:0] ALU_NOP   = 4'h0;
  localparam logic [3:0] ALU_RTYPE = 4'h1; // EX decodes funct
  localparam logic [3:0] ALU_ADD   = 4'h2;
  localparam logic [3:0] ALU_SUB   = 4'h3;
  localparam logic [3:0] ALU_AND   = 4'h4;
  localparam logic [3:0] ALU_OR    = 4'h5;
  localparam logic [3:0] ALU_XOR   = 4'h6;
  localparam logic [3:0] ALU_LUI   = 4'h7;
  localparam logic [3:0] ALU_SLT   = 4'h8;
  localparam logic [3:0] ALU_SLTU  = 4'h9;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_LWU   = 6'h27;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_JALR = 6'h09;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  function automatic logic [CTRL_W-1:0] mk_ctrl(
    input logic rw, mtr, mr, mw, asrc, rdst, lnk, input logic [3:0] aop);
    return {rw, mtr, mr, mw, asrc, rdst, lnk, aop};
  endfunction

  // Unknown opcodes and unknown R-type functs give an all-zero (NOP) word.
  function automatic logic [CTRL_W-1:0] decode_ctrl(input logic [5:0] op,
                                                   input logic [5:0] fn);
    logic [CTRL_W-1:0] c;
    c = '0;
    case (op)
      OP_RTYPE: begin
        case (fn)
          F_JALR: c = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, ALU_NOP);
          F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV,
          F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR,
          F_SLT, F_SLTU:
                  c = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ALU_RTYPE);
          default: c = '0; // includes JR: no register write
        endcase
      end
      OP_JAL:             c = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALU_NOP);
      OP_BEQ, OP_BNE:     c = mk_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALU_SUB);
      OP_ADDI, OP_ADDIU:  c = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ALU_ADD);
      OP_SLTI:            c = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ALU_SLT);
      OP_SLTIU:           c = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ALU_SLTU);
      OP_ANDI:            c = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ALU_AND);
      OP_ORI:             c = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ALU_OR);
      OP_XORI:            c = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ALU_XOR);
      OP_LUI:             c = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ALU_LUI);
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LWU:
                          c = mk_ctrl(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ALU_ADD);
      OP_SB, OP_SH, OP_SW:
                          c = mk_ctrl(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, ALU_ADD);
      default:            c = '0; // J and unknown opcodes
    endcase
    return c;
  endfunction

  // rt is read as a source operand (R-type, branches, stores)
  function automatic logic rt_is_src(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) ||
           (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/instruction_decode_register_file.sv
// General-purpose register file for the ID stage.
// Ports: i_clock/i_reset_n (async active-low clear of all registers);
//   write port i_we/i_waddr/i_wdata; combinational reads a, b and debug.
// Register 0 reads as zero and ignores writes. A read of the address being
// written this cycle returns the write data, so WB and ID can share a cycle.
module register_file
  import instruction_decode_pkg::*;
#(
  parameter int NB_REG = 32,
  parameter int N_REGS = 32
) (
  input  logic                i_clock,
  input  logic                i_reset_n,
  input  logic                i_we,
  input  logic [NB_RADDR-1:0] i_waddr,
  input  logic [NB_REG-1:0]   i_wdata,
  input  logic [NB_RADDR-1:0] i_raddr_a,
  output logic [NB_REG-1:0]   o_rdata_a,
  input  logic [NB_RADDR-1:0] i_raddr_b,
  output logic [NB_REG-1:0]   o_rdata_b,
  input  logic [NB_RADDR-1:0] i_raddr_dbg,
  output logic [NB_REG-1:0]   o_rdata_dbg
);

  logic [NB_REG-1:0] r_regs [N_REGS];
  logic              w_wr_live;

  assign w_wr_live = i_we && (i_waddr != '0);

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < N_REGS; i++) r_regs[i] <= '0;
    end else if (w_wr_live) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  always_comb begin
    o_rdata_a   = (i_raddr_a == '0)   ? '0 :
                  (w_wr_live && i_raddr_a == i_waddr)   ? i_wdata : r_regs[i_raddr_a];
    o_rdata_b   = (i_raddr_b == '0)   ? '0 :
                  (w_wr_live && i_raddr_b == i_waddr)   ? i_wdata : r_regs[i_raddr_b];
    o_rdata_dbg = (i_raddr_dbg == '0) ? '0 :
                  (w_wr_live && i_raddr_dbg == i_waddr) ? i_wdata : r_regs[i_raddr_dbg];
  end

endmodule

// File: rtl/instruction_decode.sv
// Instruction decode stage: register read, control decode, immediate
// extension, branch/jump resolution, load-use and branch-operand stall
// detection, and the ID/EX pipeline register.
// Ports: i_clock, i_reset_n (async active-low); i_valid stage enable;
//   i_ir/i_pc from fetch; i_wb_* writeback; i_mem_memread/i_mem_rd for a
//   load in MEM; o_inm_i/o_inm_j/o_rs and o_hazard/o_branch/o_jump_* to
//   fetch (combinational); o_ex_* registered ID/EX outputs; debug read port.
module instruction_decode
  import instruction_decode_pkg::*;
#(
  parameter int NB_REG   = 32,
  parameter int NB_INSTR = 32,
  parameter int N_REGS   = 32
) (
  input  logic                i_clock,
  input  logic                i_reset_n,
  input  logic                i_valid,
  input  logic [NB_INSTR-1:0] i_ir,
  input  logic [NB_REG-1:0]   i_pc,
  input  logic                i_wb_we,
  input  logic [NB_RADDR-1:0] i_wb_addr,
  input  logic [NB_REG-1:0]   i_wb_data,
  input  logic                i_mem_memread,
  input  logic [NB_RADDR-1:0] i_mem_rd,
  output logic [15:0]         o_inm_i,
  output logic [25:0]         o_inm_j,
  output logic [NB_REG-1:0]   o_rs,
  output logic                o_hazard,
  output logic                o_branch,
  output logic                o_jump_rs,
  output logic                o_jump_inm,
  output logic [NB_REG-1:0]   o_ex_rs_data,
  output logic [NB_REG-1:0]   o_ex_rt_data,
  output logic [NB_REG-1:0]   o_ex_inm,
  output logic [NB_REG-1:0]   o_ex_pc,
  output logic [NB_RADDR-1:0] o_ex_rs,
  output logic [NB_RADDR-1:0] o_ex_rt,
  output logic [NB_RADDR-1:0] o_ex_rd,
  output logic [CTRL_W-1:0]   o_ex_ctrl,
  input  logic [NB_RADDR-1:0] i_debug_reg_addr,
  output logic [NB_REG-1:0]   o_debug_reg_data
);

  logic [5:0]          w_op, w_funct;
  logic [NB_RADDR-1:0] w_rs_a, w_rt_a, w_rd_a, w_dest;
  logic [15:0]         w_imm;
  logic [NB_REG-1:0]   w_rs_data, w_rt_data, w_inm;
  logic [CTRL_W-1:0]   w_ctrl;
  logic w_is_beq, w_is_bne, w_is_jr, w_is_jimm, w_br_src, w_rt_src;
  logic w_ld_use, w_ex_hit, w_mem_hit, w_hazard, w_taken, w_go;

  // ID/EX register
  logic [NB_REG-1:0]   r_rs_data, r_rt_data, r_inm, r_pc;
  logic [NB_RADDR-1:0] r_ex_rs, r_ex_rt, r_ex_rd;
  logic [CTRL_W-1:0]   r_ctrl;

  assign w_op   = i_ir[31:26];
  assign w_rs_a = i_ir[25:21];
  assign w_rt_a = i_ir[20:16];
  assign w_rd_a = i_ir[15:11];
  assign w_imm  = i_ir[15:0];
  assign w_funct = i_ir[5:0];

  register_file #(.NB_REG(NB_REG), .N_REGS(N_REGS)) u_regs (
    .i_clock    (i_clock),
    .i_reset_n  (i_reset_n),
    .i_we       (i_wb_we),
    .i_waddr    (i_wb_addr),
    .i_wdata    (i_wb_data),
    .i_raddr_a  (w_rs_a),
    .o_rdata_a  (w_rs_data),
    .i_raddr_b  (w_rt_a),
    .o_rdata_b  (w_rt_data),
    .i_raddr_dbg(i_debug_reg_addr),
    .o_rdata_dbg(o_debug_reg_data)
  );

  assign w_ctrl    = decode_ctrl(w_op, w_funct);
  assign w_rt_src  = rt_is_src(w_op);
  assign w_is_beq  = (w_op == OP_BEQ);
  assign w_is_bne  = (w_op == OP_BNE);
  assign w_is_jr   = (w_op == OP_RTYPE) && ((w_funct == F_JR) || (w_funct == F_JALR));
  assign w_is_jimm = (w_op == OP_J) || (w_op == OP_JAL);
  assign w_br_src  = w_is_beq || w_is_bne || w_is_jr;

  // Load in EX whose result this instruction reads.
  assign w_ld_use = r_ctrl[CTRL_MEMREAD] && (r_ex_rt != '0) &&
                    ((r_ex_rt == w_rs_a) || (w_rt_src && (r_ex_rt == w_rt_a)));

  // Branches and JR resolve in ID, so any in-flight producer of their
  // operands (EX result, or a load still in MEM) must drain first.
  assign w_ex_hit  = r_ctrl[CTRL_REGWRITE] && (r_ex_rd != '0) &&
                     ((r_ex_rd == w_rs_a) || ((w_is_beq || w_is_bne) && (r_ex_rd == w_rt_a)));
  assign w_mem_hit = i_mem_memread && (i_mem_rd != '0) &&
                     ((i_mem_rd == w_rs_a) || ((w_is_beq || w_is_bne) && (i_mem_rd == w_rt_a)));

  assign w_hazard = i_valid && (w_ld_use || (w_br_src && (w_ex_hit || w_mem_hit)));
  assign w_go     = i_valid && !w_hazard;
  assign w_taken  = (w_is_beq && (w_rs_data == w_rt_data)) ||
                    (w_is_bne && (w_rs_data != w_rt_data));

  assign o_hazard   = w_hazard;
  assign o_branch   = w_go && w_taken;
  assign o_jump_rs  = w_go && w_is_jr;
  assign o_jump_inm = w_go && w_is_jimm;
  assign o_inm_i    = w_imm;
  assign o_inm_j    = i_ir[25:0];
  assign o_rs       = w_rs_data;

  always_comb begin
    w_inm = {{(NB_REG-16){w_imm[15]}}, w_imm};
    if (w_op == OP_LUI)
      w_inm = NB_REG'({w_imm, 16'h0000});
    else if ((w_op == OP_ANDI) || (w_op == OP_ORI) || (w_op == OP_XORI))
      w_inm = NB_REG'(w_imm);
  end

  assign w_dest = (w_op == OP_JAL) ? NB_RADDR'(31) :
                  w_ctrl[CTRL_REGDST] ? w_rd_a : w_rt_a;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rs_data <= '0;
      r_rt_data <= '0;
      r_inm     <= '0;
      r_pc      <= '0;
      r_ex_rs   <= '0;
      r_ex_rt   <= '0;
      r_ex_rd   <= '0;
      r_ctrl    <= '0;
    end else if (i_valid) begin
      r_rs_data <= w_rs_data;
      r_rt_data <= w_rt_data;
      r_inm     <= w_inm;
      r_pc      <= i_pc;
      r_ex_rs   <= w_rs_a;
      r_ex_rt   <= w_rt_a;
      r_ex_rd   <= w_dest;
      r_ctrl    <= w_hazard ? '0 : w_ctrl; // stall inserts a bubble
    end
  end

  assign o_ex_rs_data = r_rs_data;
  assign o_ex_rt_data = r_rt_data;
  assign o_ex_inm     = r_inm;
  assign o_ex_pc      = r_pc;
  assign o_ex_rs      = r_ex_rs;
  assign o_ex_rt      = r_ex_rt;
  assign o_ex_rd      = r_ex_rd;
  assign o_ex_ctrl    = r_ctrl;

endmodule
